md_unit: RTL and testbench

- Multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline. It sits in the E stage beside the ALU.
- It executes mult/multu/div/divu/madd/maddu/msub/msubu/mthi/mtlo over multiple cycles and exposes HI/LO for mfhi/mflo.
- It generates the MD stall request that holds the D stage while an MD result is pending.

---
 rtl/md_unit.sv | 129 ++++++++++++
 tb/tb_md_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage of the 5-stage pipeline.
// Latency: mthi/mtlo update HI/LO at the accepting edge; mult/madd/msub families take MULT_CYCLES busy cycles, div/divu take DIV_CYCLES.
// Backpressure: start is ignored while busy; md_stall holds D while an MD result is pending.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy,
  output logic        md_stall
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [63:0]   pend;

  logic [63:0] hilo;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] next_hilo;
  logic [31:0] sdiv_b;
  logic [31:0] udiv_b;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        multi_op;
  logic        b_zero;

  assign hilo     = {hi_o, lo_o};
  assign busy     = (state == RUN);
  assign multi_op = (op >= OP_MULT) && (op <= OP_MSUBU);
  assign b_zero   = (b == 32'd0);

  // Full 64-bit products; operands are pre-extended so the low 64 bits are exact.
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor is steered to 1 for b=0 (result discarded) and for MIN/-1, where
  // dividing by 1 yields exactly the wrapped quotient 0x80000000 with remainder 0.
  assign sdiv_b = (b_zero || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 32'd1 : b;
  assign udiv_b = b_zero ? 32'd1 : b;
  assign sq     = $signed(a) / $signed(sdiv_b);
  assign sr     = $signed(a) % $signed(sdiv_b);
  assign uq     = a / udiv_b;
  assign ur     = a % udiv_b;

  // Result of the multi-cycle op as it would be committed, from current HI/LO.
  always_comb begin
    next_hilo = hilo;
    case (op)
      OP_MULT:  next_hilo = prod_s;
      OP_MULTU: next_hilo = prod_u;
      OP_DIV:   next_hilo = b_zero ? hilo : {sr, sq};
      OP_DIVU:  next_hilo = b_zero ? hilo : {ur, uq};
      OP_MADD:  next_hilo = hilo + prod_s;
      OP_MADDU: next_hilo = hilo + prod_u;
      OP_MSUB:  next_hilo = hilo - prod_s;
      OP_MSUBU: next_hilo = hilo - prod_u;
      default:  next_hilo = hilo;
    endcase
  end

  // Stall D whenever an MD result is pending, including the accept cycle itself.
  assign md_stall = d_is_md & (busy | (start & multi_op));

  // Accept ops in IDLE, count down busy cycles in RUN, commit pending at the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi_o <= a;
            end else if (op == OP_MTLO) begin
              lo_o <= a;
            end else if (multi_op) begin
              pend  <= next_hilo;
              cnt   <= (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              state <= RUN;
            end
          end
        end
        default: begin
          if (cnt == CW'(1)) begin
            hi_o  <= pend[63:32];
            lo_o  <= pend[31:0];
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;
  logic        md_stall;

  int tot = 0;
  int bad = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] sb[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_is_md(d_is_md), .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // Reference model of the HI/LO result for one operation.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] acc);
    longint sx, sy, q, r;
    logic [63:0] ps, pu, ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ps = sx * sy;
    ux = {32'd0, x};
    uy = {32'd0, y};
    pu = ux * uy;
    case (o)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: begin
        if (y == 32'd0) return acc;
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (y == 32'd0) return acc;
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
      4'd5: return acc + ps;
      4'd6: return acc + pu;
      4'd7: return acc - ps;
      4'd8: return acc - pu;
      4'd9: return {x, acc[31:0]};
      4'd10: return {acc[63:32], x};
      default: return acc;
    endcase
  endfunction

  // Issue one op at the current negedge, count busy cycles, check stall and result.
  // inj=1 drives an mthi 0xDEAD in busy cycle 2, which must be ignored.
  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n, input bit inj);
    logic [63:0] e, got;
    logic        exp_st;
    int          cyc;
    e = model(o, x, y, {m_hi, m_lo});
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    exp_st = d_is_md && (o >= 4'd1) && (o <= 4'd8);
    tot++;
    if (md_stall !== exp_st) begin
      bad++;
      $display("FAIL %s accept_stall got=%b want=%b", nm, md_stall, exp_st);
    end
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tot++;
      if (md_stall !== d_is_md || {hi_o, lo_o} !== {m_hi, m_lo}) begin
        bad++;
        $display("FAIL %s busy_cycle%0d stall=%b hilo=%h want stall=%b hilo=%h",
                 nm, cyc, md_stall, {hi_o, lo_o}, d_is_md, {m_hi, m_lo});
      end
      if (inj && cyc == 2) begin
        start = 1'b1; op = 4'd9; a = 32'hDEAD;
      end else begin
        start = 1'b0; op = 4'd0;
      end
      @(negedge clk);
    end
    start = 1'b0; op = 4'd0;
    tot++;
    if (cyc != n) begin
      bad++;
      $display("FAIL %s busy_len got=%0d want=%0d", nm, cyc, n);
    end
    got = sb.pop_front();
    tot++;
    if ({hi_o, lo_o} !== got) begin
      bad++;
      $display("FAIL %s result got=%h want=%h", nm, {hi_o, lo_o}, got);
    end
    m_hi = got[63:32];
    m_lo = got[31:0];
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; d_is_md = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tot++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy !== 1'b0 || md_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_state hi=%h lo=%h busy=%b stall=%b want 0/0/0/0", hi_o, lo_o, busy, md_stall);
    end
    reset = 1'b0;
    @(negedge clk);
    run_op("pre_mthi", 4'd9, 32'h55, 32'd0, 0, 1'b0);
    run_op("pre_mtlo", 4'd10, 32'h66, 32'd0, 0, 1'b0);
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tot++;
    if (busy !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_div busy=%b hi=%h lo=%h want 0/0/0", busy, hi_o, lo_o);
    end
    repeat (12) @(negedge clk);
    tot++;
    if (busy !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_discard busy=%b hi=%h lo=%h want 0/0/0", busy, hi_o, lo_o);
    end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_mult();
    d_is_md = 1'b1;
    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 1'b0);
    tot++;
    if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFA || md_stall !== 1'b0) begin
      bad++;
      $display("FAIL mult_const hi=%h lo=%h stall=%b want ffffffff fffffffa 0", hi_o, lo_o, md_stall);
    end
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);
  endtask

  task automatic test_madd_msub();
    run_op("mthi0", 4'd9, 32'd0, 32'd0, 0, 1'b0);
    run_op("mtlo10", 4'd10, 32'd10, 32'd0, 0, 1'b0);
    tot++;
    if (lo_o !== 32'd10) begin
      bad++;
      $display("FAIL mtlo_const lo=%h want 0000000a", lo_o);
    end
    run_op("maddu", 4'd6, 32'd4, 32'd5, 5, 1'b0);
    tot++;
    if (lo_o !== 32'd30 || hi_o !== 32'd0) begin
      bad++;
      $display("FAIL maddu_const hi=%h lo=%h want 0 1e", hi_o, lo_o);
    end
    run_op("msubu", 4'd8, 32'd40, 32'd1, 5, 1'b0);
    tot++;
    if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFF6) begin
      bad++;
      $display("FAIL msubu_const hilo=%h want fffffffffffffff6", {hi_o, lo_o});
    end
    run_op("madd", 4'd5, 32'hFFFF_FFFD, 32'd7, 5, 1'b0);
    run_op("msub", 4'd7, 32'hFFFF_FFFD, 32'hFFFF_FFF0, 5, 1'b0);
  endtask

  task automatic test_div();
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
    tot++;
    if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL div_const hi=%h lo=%h want ffffffff fffffffd", hi_o, lo_o);
    end
    run_op("divu", 4'd4, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
    tot++;
    if (lo_o !== 32'h7FFF_FFFC || hi_o !== 32'd1) begin
      bad++;
      $display("FAIL divu_const hi=%h lo=%h want 00000001 7ffffffc", hi_o, lo_o);
    end
    run_op("div_pos_neg", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 1'b0);
  endtask

  task automatic test_div_zero_ovf();
    run_op("mthi11", 4'd9, 32'h11, 32'd0, 0, 1'b0);
    run_op("mtlo22", 4'd10, 32'h22, 32'd0, 0, 1'b0);
    run_op("div0", 4'd3, 32'd1234, 32'd0, 10, 1'b0);
    tot++;
    if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
      bad++;
      $display("FAIL div0_const hi=%h lo=%h want 00000011 00000022", hi_o, lo_o);
    end
    run_op("divu0", 4'd4, 32'd99, 32'd0, 10, 1'b0);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
    tot++;
    if (lo_o !== 32'h8000_0000 || hi_o !== 32'd0) begin
      bad++;
      $display("FAIL div_ovf_const hi=%h lo=%h want 00000000 80000000", hi_o, lo_o);
    end
  endtask

  task automatic test_ignored();
    run_op("div_inj", 4'd3, 32'd100, 32'd7, 10, 1'b1);
    tot++;
    if (hi_o === 32'hDEAD) begin
      bad++;
      $display("FAIL ignored_mthi hi=%h want not dead", hi_o);
    end
    start = 1'b1; op = 4'd12; a = 32'h1234; b = 32'd5;
    @(negedge clk);
    start = 1'b1; op = 4'd0;
    @(negedge clk);
    start = 1'b0;
    tot++;
    if (busy !== 1'b0 || hi_o !== m_hi || lo_o !== m_lo) begin
      bad++;
      $display("FAIL reserved_op busy=%b hilo=%h want 0 %h", busy, {hi_o, lo_o}, {m_hi, m_lo});
    end
    d_is_md = 1'b0;
    run_op("div_nostall", 4'd3, 32'd50, 32'd6, 10, 1'b0);
    run_op("mult_nostall", 4'd1, 32'd6, 32'd7, 5, 1'b0);
    d_is_md = 1'b1;
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mult", 4'd1, 32'h0001_0000, 32'h0001_0000, 5, 1'b0);
    run_op("b2b_madd", 4'd5, 32'h0001_0000, 32'h0001_0000, 5, 1'b0);
    run_op("b2b_divu", 4'd4, 32'hFFFF_FFFF, 32'd16, 10, 1'b0);
    run_op("b2b_mtlo", 4'd10, 32'hCAFE, 32'd0, 0, 1'b0);
    run_op("b2b_msubu", 4'd8, 32'd3, 32'd3, 5, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_madd_msub();
    test_div();
    test_div_zero_ovf();
    test_ignored();
    test_back_to_back();
    tot++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
